// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder reused LSB-first over WIDTH cycles,
// valid/ready handshakes on both sides. Optional two's-complement overflow
// output is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum, fa_carry;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Next-state and datapath control: load in IDLE, shift in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this final bit
          ovf_d   = carry_q ^ fa_carry;
`endif
        end
      end
      DONE: begin
        // No accept here: a new operation waits for the IDLE cycle.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against an arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  // Drive and sample 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer addition.
  function automatic logic [W:0] model_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Signed overflow: same-sign operands whose wrapped result changes sign.
  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
    logic [W:0] s;
    s = model_sum(x, y, c);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL start_op_timeout in_ready=%0b required=1", in_ready);
    end
    in_valid = 1'b1; a = x; b = y; cin = c;
    step();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin step(); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(); step();
    checks++;
    if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, {W{1'b0}}}) begin
      failures++;
      $display("FAIL reset_state got rdy=%0b vld=%0b cout=%0b sum=%h required 1 0 0 00",
               in_ready, out_valid, cout, sum);
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b required=0", ovf); end
`endif
    // Release away from the edge with a request pending: first edge must accept.
    in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL first_edge_accept in_ready=%0b required=0", in_ready);
    end
    begin
      int lat;
      wait_valid(lat);
      checks++;
      if ({out_valid, cout, sum} !== {1'b1, 1'b0, 8'h03}) begin
        failures++;
        $display("FAIL first_op got vld=%0b cout=%0b sum=%h required 1 0 03",
                 out_valid, cout, sum);
      end
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_carry_wrap();
    int lat;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== W) begin failures++; $display("FAIL wrap_latency got=%0d required=%0d", lat, W); end
    checks++;
    if ({cout, sum} !== 9'h100) begin
      failures++; $display("FAIL wrap_result got=%h required=100", {cout, sum});
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL wrap_ovf got=%0b required=0", ovf); end
`endif
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL post_handshake got rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_overflow();
    int lat;
    start_op(8'h7F, 8'h01, 1'b0);
    wait_valid(lat);
    checks++;
    if ({cout, sum} !== 9'h080) begin
      failures++; $display("FAIL ovf_case_result got=%h required=080", {cout, sum});
    end
`ifdef SERIAL_ADD_OVF_EN
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b required=1", ovf); end
`endif
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_hold();
    int lat;
    logic [W:0] exp;
    exp = model_sum(8'hA5, 8'h3C, 1'b1);
    start_op(8'hA5, 8'h3C, 1'b1);
    wait_valid(lat);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, exp}) begin
        failures++;
        $display("FAIL hold_cycle%0d got vld=%0b rdy=%0b res=%h required 1 0 %h",
                 i, out_valid, in_ready, {cout, sum}, exp);
      end
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL hold_release got rdy=%0b vld=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_in_valid();
    int lat;
    start_op(8'h22, 8'h33, 1'b0);
    step();
    in_valid = 1'b1; a = 8'h11; b = 8'h11; cin = 1'b1;
    step();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    wait_valid(lat);
    checks++;
    if ({cout, sum} !== 9'h055 || lat !== W - 2) begin
      failures++;
      $display("FAIL ignore_in_valid got res=%h lat=%0d required 055 %0d", {cout, sum}, lat, W - 2);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_op(8'hF0, 8'h0F, 1'b1);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 8'h00}) begin
      failures++;
      $display("FAIL mid_run_reset got vld=%0b rdy=%0b sum=%h required 0 1 00",
               out_valid, in_ready, sum);
    end
    step();
    rst_n = 1'b1;
    start_op(8'h05, 8'h03, 1'b1);
    wait_valid(lat);
    checks++;
    if ({out_valid, cout, sum} !== {1'b1, 9'h009}) begin
      failures++;
      $display("FAIL after_reset_op got vld=%0b res=%h required 1 009", out_valid, {cout, sum});
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y;
    logic         c;
    logic [W:0]   exp;
    int           lat;
    bit           done;
    for (int n = 0; n < 100; n++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      exp = model_sum(x, y, c);
      start_op(x, y, c);
      wait_valid(lat);
      checks++;
      if (!out_valid || lat !== W || {cout, sum} !== exp) begin
        failures++;
        $display("FAIL b2b_op%0d a=%h b=%h cin=%0b got vld=%0b lat=%0d res=%h required lat=%0d res=%h",
                 n, x, y, c, out_valid, lat, {cout, sum}, W, exp);
      end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if (ovf !== model_ovf(x, y, c)) begin
        failures++;
        $display("FAIL b2b_ovf%0d got=%0b required=%0b", n, ovf, model_ovf(x, y, c));
      end
`endif
      done = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
        out_ready = 1'($urandom);
        if (k == 49) out_ready = 1'b1;
        step();
        if (out_ready) done = 1'b1;
        else if ({out_valid, cout, sum} !== {1'b1, exp}) begin
          checks++; failures++;
          $display("FAIL b2b_hold%0d got vld=%0b res=%h required 1 %h", n, out_valid, {cout, sum}, exp);
        end
      end
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_overflow();
    test_hold();
    test_ignore_in_valid();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
